// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART transmitter: register map, STATUS/CTRL
// bit positions and the serializer state encoding.
// Optional feature: APB_UART_PARITY_EN adds an even-parity bit (8E1 frame).
package apb_uart_pkg;

    // Byte offsets of the register map
    localparam int unsigned ADDR_TXDATA  = 'h00;
    localparam int unsigned ADDR_STATUS  = 'h04;
    localparam int unsigned ADDR_CTRL    = 'h08;
    localparam int unsigned ADDR_SCRATCH = 'h10;

    // STATUS layout
    localparam int unsigned STATUS_FULL_BIT  = 0;
    localparam int unsigned STATUS_EMPTY_BIT = 1;
    localparam int unsigned STATUS_BUSY_BIT  = 2;
    localparam int unsigned STATUS_COUNT_LSB = 8;
    localparam int unsigned STATUS_COUNT_W   = 4;

    // CTRL layout
    localparam int unsigned CTRL_TX_EN_BIT  = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

endpackage

// File: rtl/apb_uart_if.sv
// APB bus bundle between a master and the UART slave.
interface apb_uart_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_uart_fifo.sv
// Synchronous show-ahead FIFO for TX bytes. DEPTH must be a power of two so
// the pointers wrap on their own.
module apb_uart_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then
    assign do_push = push && (!full || do_pop);

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/apb_uart_slave.sv
// APB slave with a TX FIFO feeding an inline UART serializer, plus CTRL,
// STATUS and scratch registers.
// Optional feature: define APB_UART_PARITY_EN for an even-parity bit (11-bit
// frame); the default build is 8N1.
module apb_uart_slave
    import apb_uart_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_REGS     = 4,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic      PCLK,
    input  logic      PRESETn,
    apb_uart_if.slave apb,
    output logic      uart_tx,
    output logic      irq
);
    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    // Register state
    logic                  tx_en_q;
    logic                  irq_en_q;
    logic [DATA_WIDTH-1:0] scratch_q [NUM_REGS];

    // FIFO interface
    logic              push;
    logic              pop;
    logic [7:0]        fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;

    // Serializer state
    tx_state_e        state_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
`ifdef APB_UART_PARITY_EN
    logic             parity_q;
`endif
    logic             bit_end;
    logic             tx_busy;

    // Decode
    logic                  aligned;
    logic                  sel_tx;
    logic                  sel_status;
    logic                  sel_ctrl;
    logic                  sel_scr;
    logic [ADDR_WIDTH-1:0] scr_off;
    logic [IDX_W-1:0]      scr_idx;
    logic                  is_err;
    logic                  stall;
    logic                  access;
    logic                  complete;
    logic                  wr_ok;
    logic [31:0]           status_word;
    logic [31:0]           ctrl_word;
    logic [DATA_WIDTH-1:0] rdata_mux;

    // Address decode, error/stall classification and read mux
    always_comb begin
        aligned    = (apb.PADDR[1:0] == 2'b00);
        sel_tx     = aligned && (apb.PADDR == ADDR_WIDTH'(ADDR_TXDATA));
        sel_status = aligned && (apb.PADDR == ADDR_WIDTH'(ADDR_STATUS));
        sel_ctrl   = aligned && (apb.PADDR == ADDR_WIDTH'(ADDR_CTRL));
        scr_off    = apb.PADDR - ADDR_WIDTH'(ADDR_SCRATCH);
        sel_scr    = aligned && (apb.PADDR >= ADDR_WIDTH'(ADDR_SCRATCH))
                     && (scr_off < ADDR_WIDTH'(4 * NUM_REGS));
        scr_idx    = scr_off[2 +: IDX_W];

        is_err = !(sel_tx || sel_status || sel_ctrl || sel_scr)
                 || (sel_status && apb.PWRITE)
                 || (sel_tx && apb.PWRITE && fifo_full && !tx_en_q);
        // Full FIFO with the transmitter running: wait for the serializer to drain one
        stall  = sel_tx && apb.PWRITE && fifo_full && tx_en_q;

        access   = apb.PSEL && apb.PENABLE && PRESETn;
        complete = access && !stall;
        wr_ok    = complete && apb.PWRITE && !is_err;
        push     = wr_ok && sel_tx;

        status_word = '0;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_BUSY_BIT]  = tx_busy;
        status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);

        ctrl_word = '0;
        ctrl_word[CTRL_TX_EN_BIT]  = tx_en_q;
        ctrl_word[CTRL_IRQ_EN_BIT] = irq_en_q;

        rdata_mux = '0;
        if (sel_status) begin
            rdata_mux = DATA_WIDTH'(status_word);
        end else if (sel_ctrl) begin
            rdata_mux = DATA_WIDTH'(ctrl_word);
        end else if (sel_scr) begin
            rdata_mux = scratch_q[scr_idx];
        end
    end

    assign apb.PREADY  = complete;
    assign apb.PSLVERR = complete && is_err;
    assign apb.PRDATA  = (access && !apb.PWRITE && !is_err) ? rdata_mux : '0;

    // CTRL and scratch register writes
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            tx_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (wr_ok) begin
            if (sel_ctrl) begin
                tx_en_q  <= apb.PWDATA[CTRL_TX_EN_BIT];
                irq_en_q <= apb.PWDATA[CTRL_IRQ_EN_BIT];
            end
            if (sel_scr) begin
                scratch_q[scr_idx] <= apb.PWDATA;
            end
        end
    end

    apb_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (push),
        .wdata (apb.PWDATA[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign tx_busy = (state_q != StIdle);
    // Popping at the end of STOP chains frames with no idle bit in between
    assign pop     = tx_en_q && !fifo_empty
                     && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    assign irq     = irq_en_q && fifo_empty && !tx_busy;

    // Serializer FSM with registered line output
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= StIdle;
            uart_tx   <= 1'b1;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef APB_UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    clk_cnt_q <= '0;
                    if (pop) begin
                        state_q <= StStart;
                        uart_tx <= 1'b0;
                        shift_q <= fifo_rdata;
`ifdef APB_UART_PARITY_EN
                        parity_q <= ^fifo_rdata;
`endif
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= StData;
                        uart_tx   <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef APB_UART_PARITY_EN
                            state_q <= StParity;
                            uart_tx <= parity_q;
`else
                            state_q <= StStop;
                            uart_tx <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            uart_tx   <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
`ifdef APB_UART_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        state_q   <= StStop;
                        uart_tx   <= 1'b1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (pop) begin
                            state_q <= StStart;
                            uart_tx <= 1'b0;
                            shift_q <= fifo_rdata;
`ifdef APB_UART_PARITY_EN
                            parity_q <= ^fifo_rdata;
`endif
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_slave.sv
// Directed-plus-random bench for apb_uart_slave: APB register behaviour and
// serial frames compared against a byte-queue model of the transmitter.
module tb_apb_uart_slave;
    localparam int unsigned CPB = 4;
    localparam int unsigned FD  = 4;
    localparam int unsigned NR  = 4;
`ifdef APB_UART_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    logic uart_tx;
    logic irq;

    apb_uart_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) apb ();

    apb_uart_slave #(
        .ADDR_WIDTH   (10),
        .DATA_WIDTH   (32),
        .NUM_REGS     (NR),
        .FIFO_DEPTH   (FD),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (apb),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_q [$];
    logic [31:0] scr_model [NR];
    int          model_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp(input int cnt, input bit busy);
        logic [31:0] s;
        s = '0;
        s[0]    = (cnt == FD);
        s[1]    = (cnt == 0);
        s[2]    = busy;
        s[11:8] = 4'(cnt);
        return s;
    endfunction

    // One APB transfer starting now (called at a falling edge)
    task automatic apb_xfer(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = wdata;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        waits = 0;
        #1;
        while (apb.PREADY !== 1'b1 && waits < 1000) begin
            @(negedge PCLK);
            #1;
            waits++;
        end
        if (apb.PREADY !== 1'b1) check("pready_timeout", apb.PREADY, 1);
        rdata = apb.PRDATA;
        err   = apb.PSLVERR;
        @(negedge PCLK);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [9:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] d;
        logic        e;
        int          w;
        apb_xfer(1'b0, addr, 32'h0, d, e, w);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_err"}, e, exp_err);
    endtask

    task automatic wr_do(input logic [9:0] addr, input logic [31:0] data,
                         output logic err, output int waits);
        logic [31:0] d;
        apb_xfer(1'b1, addr, data, d, err, waits);
    endtask

    // Waits for a start bit, then compares n whole frames sample by sample
    task automatic capture(input int n, output logic irq_seen);
        int          t;
        logic [7:0]  b;
        logic [FRAME_BITS-1:0] fr;
        logic [63:0] obs;
        logic [63:0] expv;
        irq_seen = 1'b0;
        t = 0;
        @(negedge PCLK);
        while (uart_tx !== 1'b0 && t < 3000) begin
            @(negedge PCLK);
            t++;
        end
        if (uart_tx !== 1'b0) begin
            check("frame_start_timeout", uart_tx, 0);
            return;
        end
        for (int f = 0; f < n; f++) begin
            b = exp_q.pop_front();
`ifdef APB_UART_PARITY_EN
            fr = {1'b1, ^b, b, 1'b0};
`else
            fr = {1'b1, b, 1'b0};
`endif
            obs  = '0;
            expv = '0;
            for (int k = 0; k < FRAME_BITS; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (f != 0 || k != 0 || c != 0) @(negedge PCLK);
                    obs[k*CPB+c]  = uart_tx;
                    expv[k*CPB+c] = fr[k];
                    irq_seen = irq_seen | irq;
                end
            end
            check($sformatf("frame%0d", f), obs, expv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic        irq_seen;
        int          w;
        int          w6;
        logic [31:0] d;
        logic [7:0]  b;
        int          t;

        // Access phase held during reset: outputs must still read idle
        apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b0;
        apb.PADDR = 10'h004; apb.PWDATA = '0;
        repeat (3) @(negedge PCLK);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_irq", irq, 0);
        check("rst_pready", apb.PREADY, 0);
        check("rst_prdata", apb.PRDATA, 0);
        check("rst_pslverr", apb.PSLVERR, 0);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        PRESETn = 1'b1;
        @(negedge PCLK);
        rd_check("rst_status", 10'h004, status_exp(0, 0), 1'b0);
        rd_check("rst_ctrl", 10'h008, 32'h0, 1'b0);
        rd_check("rst_scratch0", 10'h010, 32'h0, 1'b0);

        // Single 0xA5 frame
        wr_do(10'h008, 32'h1, e, w);
        wr_do(10'h000, 32'hA5, e, w);
        check("a5_push_err", e, 0);
        exp_q.push_back(8'hA5);
        capture(1, irq_seen);
        rd_check("a5_status_after", 10'h004, status_exp(0, 0), 1'b0);

        // Scratch registers, random data
        for (int i = 0; i < NR; i++) begin
            scr_model[i] = $urandom;
            wr_do(10'(16 + 4 * i), scr_model[i], e, w);
        end
        for (int i = 0; i < NR; i++) begin
            rd_check($sformatf("scratch%0d", i), 10'(16 + 4 * i), scr_model[i], 1'b0);
        end
        wr_do(10'h01C, 32'hDEADBEEF, e, w);
        rd_check("scratch3_deadbeef", 10'h01C, 32'hDEADBEEF, 1'b0);
        rd_check("unmapped_0x20", 10'h020, 32'h0, 1'b1);
        rd_check("unmapped_0x0c", 10'h00C, 32'h0, 1'b1);
        rd_check("unaligned_0x11", 10'h011, 32'h0, 1'b1);
        rd_check("txdata_read", 10'h000, 32'h0, 1'b0);
        wr_do(10'h004, 32'hFFFFFFFF, e, w);
        check("status_write_err", e, 1);
        rd_check("status_unchanged", 10'h004, status_exp(0, 0), 1'b0);
        wr_do(10'h008, 32'hFFFFFFFF, e, w);
        rd_check("ctrl_mask", 10'h008, 32'h3, 1'b0);
        check("irq_idle_enabled", irq, 1);
        wr_do(10'h008, 32'h0, e, w);
        check("irq_disabled", irq, 0);

        // Fill with transmitter off, then overflow
        model_count = 0;
        for (int i = 0; i < FD; i++) begin
            b = 8'($urandom);
            wr_do(10'h000, {24'h0, b}, e, w);
            check($sformatf("fill%0d_err", i), e, 0);
            exp_q.push_back(b);
            model_count++;
        end
        rd_check("full_status", 10'h004, status_exp(model_count, 0), 1'b0);
        wr_do(10'h000, $urandom, e, w);
        check("overflow_err", e, 1);
        check("overflow_nowait", w, 0);
        rd_check("overflow_status", 10'h004, status_exp(model_count, 0), 1'b0);
        wr_do(10'h008, 32'h1, e, w);
        capture(FD, irq_seen);
        model_count = 0;
        rd_check("drained_status", 10'h004, status_exp(0, 0), 1'b0);

        // Six back-to-back writes while transmitting; the last one stalls
        w6 = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    b = 8'($urandom);
                    wr_do(10'h000, {24'h0, b}, e, w);
                    check($sformatf("b2b%0d_err", i), e, 0);
                    exp_q.push_back(b);
                    w6 = w;
                end
            end
            begin
                capture(6, irq_seen);
            end
        join
        check("b2b_stall_seen", (w6 > 0), 1);
        rd_check("b2b_status_after", 10'h004, status_exp(0, 0), 1'b0);

        // Interrupt follows the empty-and-idle condition
        wr_do(10'h008, 32'h3, e, w);
        check("irq_before_send", irq, 1);
        b = 8'($urandom);
        wr_do(10'h000, {24'h0, b}, e, w);
        exp_q.push_back(b);
        capture(1, irq_seen);
        check("irq_low_while_busy", irq_seen, 0);
        @(negedge PCLK);
        check("irq_after_stop", irq, 1);

        // Reset in the middle of the data bits of a 0x00 frame
        wr_do(10'h008, 32'h1, e, w);
        wr_do(10'h000, 32'h00, e, w);
        t = 0;
        while (uart_tx !== 1'b0 && t < 100) begin
            @(negedge PCLK);
            t++;
        end
        repeat (CPB * 3) @(negedge PCLK);
        check("mid_data_low", uart_tx, 0);
        PRESETn = 1'b0;
        @(posedge PCLK);
        #1;
        check("abort_uart_tx", uart_tx, 1);
        check("abort_irq", irq, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        rd_check("abort_status", 10'h004, 32'h002, 1'b0);
        rd_check("abort_ctrl", 10'h008, 32'h0, 1'b0);
        rd_check("abort_scratch3", 10'h01C, 32'h0, 1'b0);
        repeat (CPB * FRAME_BITS) @(negedge PCLK);
        check("abort_line_idle", uart_tx, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_uart_slave.md
APB_UART_SLAVE -- requirements
Module: apb_uart_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width (min 8).
REQ-003 SHALL have parameter NUM_REGS, default 4, count of scratch registers.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of 2, min 2).
REQ-005 SHALL have parameter CLKS_PER_BIT, default 5208, PCLK cycles per UART bit.
REQ-006 SHALL have ports: PCLK in 1 clock; PRESETn in 1 reset; PSEL in 1; PENABLE in 1; PWRITE in 1; PADDR in ADDR_WIDTH; PWDATA in DATA_WIDTH; PRDATA out DATA_WIDTH; PREADY out 1; PSLVERR out 1; uart_tx out 1 serial line; irq out 1 level interrupt.
REQ-007 SHALL use one clock, PCLK; PRESETn is synchronous and active-low.

Function
REQ-008 SHALL decode byte addresses (word-aligned): 0x00 TXDATA (W: push PWDATA[7:0]; R: 0); 0x04 STATUS (RO); 0x08 CTRL (RW); 0x10+4*i SCRATCH[i], i<NUM_REGS (RW).
REQ-009 SHALL format STATUS as: bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bits[11:8] fifo count, other bits 0.
REQ-010 SHALL format CTRL as: bit0 tx_en, bit1 irq_en, other bits read 0.
REQ-011 SHALL treat the setup phase as PSEL&!PENABLE and the access phase as PSEL&PENABLE; all register effects occur only in the access-phase cycle with PREADY=1.
REQ-012 SHALL drive PREADY=1 in every access phase, except a TXDATA write while the FIFO is full and tx_en=1: there PREADY=0 until a pop frees an entry, and the push completes in the first cycle PREADY=1.
REQ-013 SHALL complete with PREADY=1, PSLVERR=1 and no side effect for: an unmapped or unaligned address, a write to STATUS, or a TXDATA write when the FIFO is full and tx_en=0.
REQ-014 SHALL drive PRDATA with the read value during the access phase of a read, and 0 otherwise.
REQ-015 SHALL drive PSLVERR=0 outside a completing errored access.
REQ-016 SHALL run the serializer FSM IDLE->START->DATA->[PARITY]->STOP->IDLE, holding each state for CLKS_PER_BIT cycles.
- DATA is LSB first, 8 bits.
- uart_tx=1 in IDLE and STOP, 0 in START.
REQ-017 SHALL pop the FIFO and move IDLE->START in the same cycle when tx_en=1 and the FIFO is non-empty.
- Back-to-back frames leave no idle bit between them.
REQ-018 SHALL let a frame already in progress finish when tx_en is cleared; no further pops occur.
REQ-019 SHALL, on a simultaneous push and pop, perform both and leave the count unchanged.
REQ-020 SHALL assert tx_busy whenever the FSM is not in IDLE.
REQ-021 SHALL drive irq = irq_en & fifo_empty & !tx_busy.

Reset
REQ-022 SHALL, with PRESETn=0 at a PCLK edge, apply: PRDATA=0, PREADY=0, PSLVERR=0, uart_tx=1, irq=0, FIFO empty, FSM IDLE, CTRL=0, SCRATCH=0.
REQ-023 SHALL abort a frame or stalled access on reset mid-operation; uart_tx returns to 1 on the next edge.

Configuration
REQ-024 SHALL, with APB_UART_PARITY_EN defined, include the PARITY state (even parity over the 8 data bits, giving an 11-bit frame); without it, SHALL use 8N1 (10-bit frame) with no parity logic.

Structure
REQ-025 SHALL place the register offsets, the STATUS/CTRL bit positions and the FSM state enum in a shared package, apb_uart_pkg.
REQ-026 SHALL implement the TX FIFO as the sub-module apb_uart_fifo (synchronous; push, pop, full, empty, count); the serializer stays inline.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 SHALL cover: write CTRL=0x1, then TXDATA=0xA5 -> uart_tx shows 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles, and tx_busy clears afterwards.
REQ-028 SHALL cover: tx_en=0, 4 TXDATA writes then a 5th -> STATUS.full=1, count=4; the 5th completes with PSLVERR=1 and count stays 4.
REQ-029 SHALL cover: tx_en=1, 6 back-to-back TXDATA writes -> PREADY low on the stalled write until a pop occurs; all 6 bytes are serialized in order with no gaps.
REQ-030 SHALL cover: write SCRATCH[3] (0x1C)=0xDEADBEEF and read it back -> 0xDEADBEEF; read 0x20 -> PSLVERR=1, PRDATA=0.
REQ-031 SHALL cover: PRESETn=0 mid-DATA -> next edge gives uart_tx=1, STATUS=0x002, CTRL=0.
REQ-032 SHALL cover: irq_en=1 with a single byte sent -> irq=0 while busy and irq=1 one cycle after STOP ends.
